// File: rtl/bsg_mem_1rw_sync_mask_write_byte_pkg.sv
// Shared constants, access-kind encoding and helpers for the byte-masked
// single-port synchronous memory.
package bsg_mem_1rw_sync_mask_write_byte_pkg;

    localparam int unsigned byte_width_lp = 8;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE,
        OP_RESET
    } op_e;

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Reset wins over any access presented in the same cycle.
    function automatic op_e decode_op(input logic reset, input logic v, input logic w);
        if (reset)  return OP_RESET;
        if (!v)     return OP_IDLE;
        return w ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_lane.sv
// One byte-wide synchronous 1RW storage lane with a registered read port.
module bsg_mem_1rw_sync_mask_write_byte_lane
    import bsg_mem_1rw_sync_mask_write_byte_pkg::*;
#(
    parameter int unsigned els_p        = 1024,
    parameter int unsigned addr_width_p = 10
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_i,
    input  logic                     rd_i,
    input  logic                     rd_zero_i,
    input  logic [addr_width_p-1:0]  addr_i,
    input  logic [byte_width_lp-1:0] data_i,
    output logic [byte_width_lp-1:0] data_o
);

    logic [byte_width_lp-1:0] mem_q [els_p];
    logic [byte_width_lp-1:0] data_q;
    logic [byte_width_lp-1:0] data_d;

    // Storage is deliberately not reset; contents persist across reset_i.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    always_comb begin
        data_d = data_q;
        if (rd_i) begin
            data_d = rd_zero_i ? '0 : mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write mask and 1-cycle read latency;
// built as one byte lane per mask bit.
module bsg_mem_1rw_sync_mask_write_byte
    import bsg_mem_1rw_sync_mask_write_byte_pkg::*;
#(
    parameter int unsigned els_p        = 1024,
    parameter int unsigned data_width_p = 32,
    localparam int unsigned addr_width_lp       = safe_clog2(els_p),
    localparam int unsigned write_mask_width_lp = data_width_p / byte_width_lp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]        data_o
);

    if (data_width_p == 0 || (data_width_p % byte_width_lp) != 0) begin : g_bad_width
        $error("data_width_p (%0d) must be a nonzero multiple of 8", data_width_p);
    end
    if (els_p == 0) begin : g_bad_els
        $error("els_p must be at least 1");
    end

    op_e  op;
    logic in_range;
    logic wr;
    logic rd;

    // A power-of-two depth cannot be addressed out of range.
    if ((64'd1 << addr_width_lp) == 64'(els_p)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_partial_range
        assign in_range = (addr_i < addr_width_lp'(els_p));
    end

    always_comb begin
        op = decode_op(reset_i, v_i, w_i);
        wr = (op == OP_WRITE) && in_range;
        rd = (op == OP_READ);
    end

    for (genvar i = 0; i < write_mask_width_lp; i++) begin : g_lane
        bsg_mem_1rw_sync_mask_write_byte_lane #(
            .els_p        (els_p),
            .addr_width_p (addr_width_lp)
        ) u_lane (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .wr_i      (wr && write_mask_i[i]),
            .rd_i      (rd),
            .rd_zero_i (!in_range),
            .addr_i    (addr_i),
            .data_i    (data_i[i*byte_width_lp +: byte_width_lp]),
            .data_o    (data_o[i*byte_width_lp +: byte_width_lp])
        );
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i === 1'b0) begin
            assert (!$isunknown(v_i))
                else $error("v_i is unknown outside reset");
            if (v_i === 1'b1) begin
                assert (!$isunknown(w_i))
                    else $error("w_i is unknown on a valid access");
                assert (in_range)
                    else $error("out-of-range address %0d (els_p=%0d)", addr_i, els_p);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte.sv
// Directed self-checking bench for the byte-masked 1RW synchronous memory
// (els_p=1024, data_width_p=32).
module tb_bsg_mem_1rw_sync_mask_write_byte;

    logic        clk_i;
    logic        reset_i;
    logic        v_i;
    logic        w_i;
    logic [9:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  write_mask_i;
    logic [31:0] data_o;

    int unsigned npass;
    int unsigned ntotal;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (1024),
        .data_width_p (32)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .write_mask_i (write_mask_i),
        .data_o       (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic v, input logic w,
                        input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        reset_i      = rst;
        v_i          = v;
        w_i          = w;
        addr_i       = a;
        data_i       = d;
        write_mask_i = m;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        ntotal++;
        assert (data_o === exp) npass++;
        else $error("FAIL %s: data_o=%h expected %h", tag, data_o, exp);
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0;
        addr_i = '0; data_i = '0; write_mask_i = '0;

        step(1, 0, 0, 10'd0, 32'h0, 4'h0);
        check("reset_zero", 32'h0000_0000);

        step(0, 1, 1, 10'd5, 32'hDEAD_BEEF, 4'hF);
        check("write_no_update", 32'h0000_0000);
        step(0, 1, 0, 10'd5, 32'h0, 4'h0);
        check("full_write_read", 32'hDEAD_BEEF);

        step(0, 1, 1, 10'd5, 32'h1122_3344, 4'b0101);
        check("partial_write_hold", 32'hDEAD_BEEF);
        step(0, 1, 0, 10'd5, 32'h0, 4'h0);
        check("partial_write_read", 32'hDE22_BE44);

        step(0, 0, 0, 10'd9, 32'hFFFF_FFFF, 4'hF);
        check("idle_hold_1", 32'hDE22_BE44);
        step(0, 0, 1, 10'd5, 32'h0, 4'hF);
        check("idle_hold_2", 32'hDE22_BE44);
        step(0, 0, 0, 10'd3, 32'h1234_5678, 4'h0);
        check("idle_hold_3", 32'hDE22_BE44);
        step(0, 1, 1, 10'd7, 32'h0, 4'hF);
        check("write7_hold", 32'hDE22_BE44);
        step(0, 1, 0, 10'd5, 32'h0, 4'h0);
        check("idle_ignored_read5", 32'hDE22_BE44);

        step(0, 1, 1, 10'd0,    32'hA5A5_A5A5, 4'hF);
        step(0, 1, 1, 10'd1023, 32'h5A5A_5A5A, 4'hF);
        step(0, 1, 0, 10'd0, 32'h0, 4'h0);
        check("addr0_read", 32'hA5A5_A5A5);
        step(0, 1, 0, 10'd1023, 32'h0, 4'h0);
        check("addr1023_read", 32'h5A5A_5A5A);
        step(0, 1, 0, 10'd7, 32'h0, 4'h0);
        check("addr7_read", 32'h0000_0000);

        step(0, 1, 0, 10'd0, 32'h0, 4'h0);
        step(1, 1, 1, 10'd5, 32'h0, 4'hF);
        check("reset_with_write", 32'h0000_0000);
        step(0, 1, 0, 10'd5, 32'h0, 4'h0);
        check("contents_preserved", 32'hDE22_BE44);

        step(0, 1, 0, 10'd0, 32'h0, 4'h0);
        step(1, 1, 0, 10'd0, 32'h0, 4'h0);
        check("reset_with_read", 32'h0000_0000);

        step(0, 1, 1, 10'd0, 32'hFFFF_FFFF, 4'h0);
        step(0, 1, 0, 10'd0, 32'h0, 4'h0);
        check("zero_mask", 32'hA5A5_A5A5);

        step(0, 1, 1, 10'd1, 32'h0BAD_F00D, 4'hF);
        step(0, 0, 1, 10'd1, 32'h0, 4'hF);
        step(0, 1, 1, 10'd1, 32'hFFFF_FFFF, 4'b1000);
        step(0, 1, 0, 10'd1, 32'h0, 4'h0);
        check("idle_write_ignored", 32'hFFAD_F00D);

        step(0, 0, 0, 10'd0, 32'h0, 4'h0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
